// File: rtl/sign_extend_8to16.sv
//==============================================================================
// Module   : sign_extend_8to16
// Brief    : Registered 8->16 immediate extender (sign / zero / sign<<1 / high
//            byte) for the ALU B-operand path. Optional flags: SEXT_FLAGS_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module sign_extend_8to16 #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  a,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic [OUT_W-1:0] r,
    output logic             out_valid
`ifdef SEXT_FLAGS_EN
    ,
    output logic             r_neg,
    output logic             r_zero
`endif
);

    localparam logic [1:0] c_MODE_SEXT   = 2'b00;
    localparam logic [1:0] c_MODE_ZEXT   = 2'b01;
    localparam logic [1:0] c_MODE_SEXT_1 = 2'b10;
    localparam logic [1:0] c_MODE_HIGH   = 2'b11;

    localparam int c_EXT_W = OUT_W - IN_W;

    logic [OUT_W-1:0] w_ext;
    logic             w_sign;

    assign w_sign = a[IN_W-1];

    // The shifted mode drops one replicated sign bit so the sign survives the shift.
    always_comb begin
        w_ext = '0;
        case (mode)
            c_MODE_SEXT:   w_ext = {{c_EXT_W{w_sign}}, a};
            c_MODE_ZEXT:   w_ext = {{c_EXT_W{1'b0}}, a};
            c_MODE_SEXT_1: w_ext = {{(c_EXT_W-1){w_sign}}, a, 1'b0};
            c_MODE_HIGH:   w_ext = {a, {c_EXT_W{1'b0}}};
            default:       w_ext = '0;
        endcase
    end

    logic [OUT_W-1:0] r_result;
    logic             r_valid;

    // Result holds when no input is qualified; only the valid flag drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_result <= w_ext;
            end
        end
    end

    assign r         = r_result;
    assign out_valid = r_valid;

`ifdef SEXT_FLAGS_EN
    logic r_neg_q;
    logic r_zero_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_neg_q  <= 1'b0;
            r_zero_q <= 1'b0;
        end else if (in_valid) begin
            r_neg_q  <= w_ext[OUT_W-1];
            r_zero_q <= (w_ext == '0);
        end
    end

    assign r_neg  = r_neg_q;
    assign r_zero = r_zero_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sign_extend_8to16.sv
//==============================================================================
// Module   : tb_sign_extend_8to16
// Brief    : Self-checking bench for sign_extend_8to16 (vector table + queue).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sign_extend_8to16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  a;
    logic [1:0]  mode;
    logic        in_valid;
    logic [15:0] r;
    logic        out_valid;
`ifdef SEXT_FLAGS_EN
    logic        r_neg;
    logic        r_zero;
`endif

    sign_extend_8to16 dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .mode      (mode),
        .in_valid  (in_valid),
        .r         (r),
        .out_valid (out_valid)
`ifdef SEXT_FLAGS_EN
        ,
        .r_neg     (r_neg),
        .r_zero    (r_zero)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [1:0]  mode;
        logic [15:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] sb_q[$];
    int          n_tests = 0;
    int          n_failed = 0;
    logic        exp_v;
    logic [15:0] last_r;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected valid is the in_valid seen by the previous edge.
    always @(posedge clk or posedge rst) begin
        if (rst) exp_v <= 1'b0;
        else     exp_v <= in_valid;
    end

    always @(negedge clk) begin
        logic [15:0] e;
        if (rst) begin
            chk("reset_r", r, 16'h0000);
            chk("reset_valid", {15'd0, out_valid}, 16'd0);
            last_r = 16'h0000;
        end else begin
            chk("out_valid", {15'd0, out_valid}, {15'd0, exp_v});
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_output", 16'd1, 16'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("result", r, e);
`ifdef SEXT_FLAGS_EN
                    chk("r_neg", {15'd0, r_neg}, {15'd0, e[15]});
                    chk("r_zero", {15'd0, r_zero}, {15'd0, (e == 16'h0000)});
`endif
                    last_r = e;
                end
            end else begin
                chk("hold_r", r, last_r);
            end
        end
    end

    task automatic drive(input logic [7:0] av, input logic [1:0] mv, input logic [15:0] ev);
        @(negedge clk);
        a        = av;
        mode     = mv;
        in_valid = 1'b1;
        sb_q.push_back(ev);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        a        = 8'h00;
        mode     = 2'b00;
        in_valid = 1'b0;

        // Sweep mode 00 in steps of 0x10.
        for (int i = 0; i < 16; i++) begin
            logic [7:0] av;
            av = 8'(i * 16);
            vecs.push_back('{av, 2'b00,
                (av >= 8'h80) ? (16'hFF00 | {8'h00, av}) : {8'h00, av}});
        end
        vecs.push_back('{8'hA5, 2'b00, 16'hFFA5});
        vecs.push_back('{8'hA5, 2'b01, 16'h00A5});
        vecs.push_back('{8'hA5, 2'b10, 16'hFF4A});
        vecs.push_back('{8'hA5, 2'b11, 16'hA500});
        vecs.push_back('{8'h7F, 2'b00, 16'h007F});
        vecs.push_back('{8'h80, 2'b00, 16'hFF80});
        vecs.push_back('{8'hFF, 2'b10, 16'hFFFE});
        vecs.push_back('{8'h80, 2'b10, 16'hFF00});
        vecs.push_back('{8'h3C, 2'b10, 16'h0078});
        vecs.push_back('{8'h01, 2'b00, 16'h0001});
        vecs.push_back('{8'hFE, 2'b00, 16'hFFFE});
        vecs.push_back('{8'h7F, 2'b00, 16'h007F});

        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].a, vecs[i].mode, vecs[i].exp);
        end
        idle(2);

        // Valid gating: one-cycle pulse, result held afterwards.
        drive(8'h12, 2'b00, 16'h0012);
        idle(3);
        chk("gated_hold", r, 16'h0012);
        chk("gated_valid", {15'd0, out_valid}, 16'd0);

        // Asynchronous reset between edges while a result is valid.
        drive(8'h55, 2'b01, 16'h0055);
        @(posedge clk);
        #2;
        chk("pre_reset_valid", {15'd0, out_valid}, 16'd1);
        #1;
        rst = 1'b1;
        sb_q.delete();
        #1;
        chk("async_reset_r", r, 16'h0000);
        chk("async_reset_valid", {15'd0, out_valid}, 16'd0);
        in_valid = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;

        // First result after reset release.
        drive(8'h80, 2'b11, 16'h8000);
        idle(3);
        chk("queue_drained", 16'(sb_q.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule

`default_nettype wire
